// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size, exception and FSM encodings for the memory stage
package mem_stage_pkg;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_W    = 2'd1;
    localparam logic [1:0] MEM_H    = 2'd2;
    localparam logic [1:0] MEM_B    = 2'd3;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory req/ack bus between the memory stage and memory
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - little-endian byte-lane steering, store replication and load extension
module mem_lane
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [15:0] w_lane;

    always_comb begin
        // Move the addressed lane down to bit 0 before extension.
        w_lane       = 16'(i_rdata >> {i_addr, 3'b000});
        o_be         = 4'b0000;
        o_wdata      = i_store_data;
        o_load_data  = 32'd0;
        o_misaligned = 1'b0;
        case (i_size)
            MEM_W: begin
                o_be         = 4'b1111;
                o_load_data  = i_rdata;
                o_misaligned = |i_addr;
            end
            MEM_H: begin
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_lane[15]}}, w_lane};
                o_misaligned = i_addr[0];
            end
            MEM_B: begin
                o_be         = 4'b0001 << i_addr;
                o_wdata      = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_lane[7]}}, w_lane[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: bus handshake, stall, branch redirect, MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] EXMEM_pc_branch_in,
    input  logic [31:0] EXMEM_alu_in,
    input  logic        EXMEM_alu_do_branch_in,
    input  logic [31:0] EXMEM_b_in,
    input  logic [4:0]  EXMEM_rd_in,
    input  logic        EXMEM_ctrl_branch_in,
    input  logic [1:0]  EXMEM_ctrl_mem_read_in,
    input  logic [1:0]  EXMEM_ctrl_mem_write_in,
    input  logic        EXMEM_ctrl_reg_write_in,
    input  logic        EXMEM_ctrl_mem_to_reg_in,
    mem_stage_if.master dmem,
    output logic        stall_out,
    output logic        pc_src_out,
    output logic [31:0] pc_branch_out,
    output logic [31:0] MEMWB_read_data_out,
    output logic [31:0] MEMWB_alu_out,
    output logic [4:0]  MEMWB_rd_out,
    output logic        MEMWB_ctrl_reg_write_out,
    output logic        MEMWB_ctrl_mem_to_reg_out,
    output logic [1:0]  MEMWB_exc_out
);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        w_is_write, w_mem_op, w_misaligned, w_timeout_hit;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    assign w_is_write = |EXMEM_ctrl_mem_write_in;
    assign w_mem_op   = w_is_write | (|EXMEM_ctrl_mem_read_in);
    assign w_size     = w_is_write ? EXMEM_ctrl_mem_write_in : EXMEM_ctrl_mem_read_in;

    mem_lane u_lane (
        .i_size       (w_size),
        .i_addr       (EXMEM_alu_in[1:0]),
        .i_store_data (EXMEM_b_in),
        .i_rdata      (dmem.rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

    // Upstream holds EX/MEM while stalled, so the lane inputs stay valid through WAIT.
    assign stall_out = ~rst_in &
                       (((r_state == ST_IDLE) & w_mem_op & ~w_misaligned) |
                        ((r_state == ST_WAIT) & ~dmem.ack));
    assign pc_src_out    = ~rst_in & EXMEM_ctrl_branch_in & EXMEM_alu_do_branch_in & ~stall_out;
    assign pc_branch_out = EXMEM_pc_branch_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state                   <= ST_IDLE;
            r_cnt                     <= 32'd0;
            dmem.req                  <= 1'b0;
            dmem.we                   <= 1'b0;
            dmem.addr                 <= 32'd0;
            dmem.be                   <= 4'b0000;
            dmem.wdata                <= 32'd0;
            MEMWB_read_data_out       <= 32'd0;
            MEMWB_alu_out             <= 32'd0;
            MEMWB_rd_out              <= 5'd0;
            MEMWB_ctrl_reg_write_out  <= 1'b0;
            MEMWB_ctrl_mem_to_reg_out <= 1'b0;
            MEMWB_exc_out             <= EXC_NONE;
        end else begin
            MEMWB_alu_out       <= EXMEM_alu_in;
            MEMWB_rd_out        <= EXMEM_rd_in;
            MEMWB_read_data_out <= 32'd0;
            MEMWB_exc_out       <= EXC_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op && w_misaligned) begin
                        MEMWB_ctrl_reg_write_out  <= 1'b0;
                        MEMWB_ctrl_mem_to_reg_out <= 1'b0;
                        MEMWB_exc_out             <= EXC_MISALIGN;
                    end else if (w_mem_op) begin
                        r_state                   <= ST_WAIT;
                        r_cnt                     <= 32'd0;
                        dmem.req                  <= 1'b1;
                        dmem.we                   <= w_is_write;
                        dmem.addr                 <= {EXMEM_alu_in[31:2], 2'b00};
                        dmem.be                   <= w_be;
                        dmem.wdata                <= w_wdata;
                        MEMWB_ctrl_reg_write_out  <= 1'b0;
                        MEMWB_ctrl_mem_to_reg_out <= 1'b0;
                    end else begin
                        MEMWB_ctrl_reg_write_out  <= EXMEM_ctrl_reg_write_in;
                        MEMWB_ctrl_mem_to_reg_out <= EXMEM_ctrl_mem_to_reg_in;
                    end
                end
                ST_WAIT: begin
                    if (dmem.ack) begin
                        r_state                   <= ST_IDLE;
                        dmem.req                  <= 1'b0;
                        MEMWB_read_data_out       <= dmem.we ? 32'd0 : w_load_data;
                        MEMWB_ctrl_reg_write_out  <= EXMEM_ctrl_reg_write_in;
                        MEMWB_ctrl_mem_to_reg_out <= EXMEM_ctrl_mem_to_reg_in;
                    end else if (w_timeout_hit) begin
                        r_state                   <= ST_IDLE;
                        dmem.req                  <= 1'b0;
                        MEMWB_ctrl_reg_write_out  <= 1'b0;
                        MEMWB_ctrl_mem_to_reg_out <= 1'b0;
                        MEMWB_exc_out             <= EXC_TIMEOUT;
                    end else begin
                        r_cnt                     <= r_cnt + 32'd1;
                        MEMWB_ctrl_reg_write_out  <= 1'b0;
                        MEMWB_ctrl_mem_to_reg_out <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] EXMEM_pc_branch_in, EXMEM_alu_in, EXMEM_b_in;
    logic        EXMEM_alu_do_branch_in, EXMEM_ctrl_branch_in;
    logic [4:0]  EXMEM_rd_in;
    logic [1:0]  EXMEM_ctrl_mem_read_in, EXMEM_ctrl_mem_write_in;
    logic        EXMEM_ctrl_reg_write_in, EXMEM_ctrl_mem_to_reg_in;
    logic        stall_out, pc_src_out;
    logic [31:0] pc_branch_out, MEMWB_read_data_out, MEMWB_alu_out;
    logic [4:0]  MEMWB_rd_out;
    logic        MEMWB_ctrl_reg_write_out, MEMWB_ctrl_mem_to_reg_out;
    logic [1:0]  MEMWB_exc_out;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .EXMEM_pc_branch_in        (EXMEM_pc_branch_in),
        .EXMEM_alu_in              (EXMEM_alu_in),
        .EXMEM_alu_do_branch_in    (EXMEM_alu_do_branch_in),
        .EXMEM_b_in                (EXMEM_b_in),
        .EXMEM_rd_in               (EXMEM_rd_in),
        .EXMEM_ctrl_branch_in      (EXMEM_ctrl_branch_in),
        .EXMEM_ctrl_mem_read_in    (EXMEM_ctrl_mem_read_in),
        .EXMEM_ctrl_mem_write_in   (EXMEM_ctrl_mem_write_in),
        .EXMEM_ctrl_reg_write_in   (EXMEM_ctrl_reg_write_in),
        .EXMEM_ctrl_mem_to_reg_in  (EXMEM_ctrl_mem_to_reg_in),
        .dmem                      (dmem),
        .stall_out                 (stall_out),
        .pc_src_out                (pc_src_out),
        .pc_branch_out             (pc_branch_out),
        .MEMWB_read_data_out       (MEMWB_read_data_out),
        .MEMWB_alu_out             (MEMWB_alu_out),
        .MEMWB_rd_out              (MEMWB_rd_out),
        .MEMWB_ctrl_reg_write_out  (MEMWB_ctrl_reg_write_out),
        .MEMWB_ctrl_mem_to_reg_out (MEMWB_ctrl_mem_to_reg_out),
        .MEMWB_exc_out             (MEMWB_exc_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stalls;
    int          req_cycles;
    logic        cap_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_exmem(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd,
                             input logic [1:0] rsz, input logic [1:0] wsz,
                             input logic rw, input logic m2r);
        EXMEM_alu_in             = alu;
        EXMEM_b_in               = b;
        EXMEM_rd_in              = rd;
        EXMEM_ctrl_mem_read_in   = rsz;
        EXMEM_ctrl_mem_write_in  = wsz;
        EXMEM_ctrl_reg_write_in  = rw;
        EXMEM_ctrl_mem_to_reg_in = m2r;
        EXMEM_ctrl_branch_in     = 1'b0;
        EXMEM_alu_do_branch_in   = 1'b0;
        EXMEM_pc_branch_in       = 32'd0;
    endtask

    // Called in the cycle the op is presented; returns after the completing edge.
    task automatic do_op(input int ack_at, output int n_stall);
        n_stall = 0;
        cap_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            dmem.ack = (c == ack_at);
            #1;
            if (c == 1) begin
                cap_req   = dmem.req;
                cap_we    = dmem.we;
                cap_addr  = dmem.addr;
                cap_be    = dmem.be;
                cap_wdata = dmem.wdata;
            end
            if (!stall_out) break;
            n_stall++;
            if (c == 39) check("op_bound", 32'(stall_out), 32'd0);
            step();
        end
        step();
        dmem.ack = 1'b0;
        set_exmem(32'd0, 32'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_in     = 1'b1;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'd0;
        set_exmem(32'h55, 32'd0, 5'd9, 2'd0, 2'd0, 1'b1, 1'b1);
        step();
        step();
        check("rst_req", 32'(dmem.req), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_wb_alu", MEMWB_alu_out, 32'd0);
        check("rst_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd0);
        rst_in = 1'b0;

        // Non-mem op with a stray ack in IDLE
        dmem.rdata = 32'hCAFEF00D;
        set_exmem(32'h1234, 32'd0, 5'd3, 2'd0, 2'd0, 1'b1, 1'b0);
        do_op(0, stalls);
        check("alu_stalls", 32'(stalls), 32'd0);
        check("alu_wb_alu", MEMWB_alu_out, 32'h1234);
        check("alu_wb_rd", 32'(MEMWB_rd_out), 32'd3);
        check("alu_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd1);
        check("alu_wb_rdata", MEMWB_read_data_out, 32'd0);
        check("idle_ack_req", 32'(dmem.req), 32'd0);

        // Store word, ack three cycles in
        set_exmem(32'h100, 32'hDEADBEEF, 5'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        do_op(3, stalls);
        check("sw_stalls", 32'(stalls), 32'd3);
        check("sw_req", 32'(cap_req), 32'd1);
        check("sw_we", 32'(cap_we), 32'd1);
        check("sw_addr", cap_addr, 32'h100);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check("sw_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd0);
        check("sw_req_done", 32'(dmem.req), 32'd0);

        // Store byte to 0x103
        set_exmem(32'h103, 32'h000000A5, 5'd0, 2'd0, 2'd3, 1'b0, 1'b0);
        do_op(1, stalls);
        check("sb_addr", cap_addr, 32'h100);
        check("sb_be", 32'(cap_be), 32'h8);
        check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        check("sb_stalls", 32'(stalls), 32'd1);

        // Store half to 0x102
        set_exmem(32'h102, 32'hFFFF1234, 5'd0, 2'd0, 2'd2, 1'b0, 1'b0);
        do_op(1, stalls);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'h12341234);

        // Load byte from 0x103
        dmem.rdata = 32'hA5000000;
        set_exmem(32'h103, 32'd0, 5'd5, 2'd3, 2'd0, 1'b1, 1'b1);
        do_op(2, stalls);
        check("lb_stalls", 32'(stalls), 32'd2);
        check("lb_we", 32'(cap_we), 32'd0);
        check("lb_data", MEMWB_read_data_out, 32'hFFFFFFA5);
        check("lb_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd1);
        check("lb_wb_m2r", 32'(MEMWB_ctrl_mem_to_reg_out), 32'd1);
        check("lb_wb_rd", 32'(MEMWB_rd_out), 32'd5);

        // Load half from 0x102, immediate ack
        dmem.rdata = 32'h80010000;
        set_exmem(32'h102, 32'd0, 5'd6, 2'd2, 2'd0, 1'b1, 1'b1);
        do_op(1, stalls);
        check("lh_stalls", 32'(stalls), 32'd1);
        check("lh_be", 32'(cap_be), 32'hC);
        check("lh_data", MEMWB_read_data_out, 32'hFFFF8001);

        // Load half from 0x100, positive value
        dmem.rdata = 32'hFFFF7FFF;
        set_exmem(32'h100, 32'd0, 5'd6, 2'd2, 2'd0, 1'b1, 1'b1);
        do_op(1, stalls);
        check("lh0_be", 32'(cap_be), 32'h3);
        check("lh0_data", MEMWB_read_data_out, 32'h00007FFF);

        // Misaligned load word
        set_exmem(32'h2, 32'd0, 5'd4, 2'd1, 2'd0, 1'b1, 1'b1);
        do_op(-1, stalls);
        check("mis_stalls", 32'(stalls), 32'd0);
        check("mis_req", 32'(dmem.req), 32'd0);
        check("mis_exc", 32'(MEMWB_exc_out), 32'd1);
        check("mis_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd0);

        // Timeout with TIMEOUT=4
        set_exmem(32'h200, 32'd0, 5'd8, 2'd1, 2'd0, 1'b1, 1'b1);
        req_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!dmem.req) break;
            req_cycles++;
        end
        check("to_wait_cycles", 32'(req_cycles), 32'd4);
        check("to_exc", 32'(MEMWB_exc_out), 32'd2);
        check("to_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd0);
        check("to_req", 32'(dmem.req), 32'd0);
        set_exmem(32'd0, 32'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        check("to_idle_stall", 32'(stall_out), 32'd0);

        // Reset mid-WAIT with coincident ack
        set_exmem(32'h300, 32'd0, 5'd7, 2'd1, 2'd0, 1'b1, 1'b1);
        step();
        step();
        check("rw_req_before", 32'(dmem.req), 32'd1);
        rst_in     = 1'b1;
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h12345678;
        step();
        rst_in   = 1'b0;
        dmem.ack = 1'b0;
        set_exmem(32'd0, 32'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        check("rw_req", 32'(dmem.req), 32'd0);
        check("rw_wb_rdata", MEMWB_read_data_out, 32'd0);
        check("rw_wb_rd", 32'(MEMWB_rd_out), 32'd0);
        check("rw_wb_rw", 32'(MEMWB_ctrl_reg_write_out), 32'd0);
        step();
        check("rw_req_after", 32'(dmem.req), 32'd0);

        // Branch while a load is outstanding, then in IDLE
        set_exmem(32'h400, 32'd0, 5'd2, 2'd1, 2'd0, 1'b1, 1'b1);
        EXMEM_ctrl_branch_in   = 1'b1;
        EXMEM_alu_do_branch_in = 1'b1;
        EXMEM_pc_branch_in     = 32'h40;
        #1;
        check("br_idle_stall_src", 32'(pc_src_out), 32'd0);
        step();
        check("br_wait_src", 32'(pc_src_out), 32'd0);
        dmem.ack = 1'b1;
        step();
        dmem.ack = 1'b0;
        set_exmem(32'h0, 32'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        EXMEM_ctrl_branch_in   = 1'b1;
        EXMEM_alu_do_branch_in = 1'b1;
        EXMEM_pc_branch_in     = 32'h40;
        #1;
        check("br_src", 32'(pc_src_out), 32'd1);
        check("br_target", pc_branch_out, 32'h40);
        EXMEM_alu_do_branch_in = 1'b0;
        #1;
        check("br_not_taken", 32'(pc_src_out), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
